// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants and the counter-width helper for the fetch front end.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Instruction field positions, shared with decode
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_B5  = 30;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_buffer.sv
// Synchronous instruction FIFO; flush empties it and overrides a same-cycle push.
module inst_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [ILEN-1:0]               data_i,
  output logic [ILEN-1:0]               head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [ILEN-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [CW-1:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: in-order credit-limited requests, buffered delivery, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_misalign and stall fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misalign
);

  localparam int CW = cnt_width(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   buf_count;
  logic [CW:0]     credit_used;
  logic [CW:0]     stale_total;
  logic [XLEN-1:0] target_pc;
  logic            target_mis;
  logic            misalign;
  logic            buf_full, buf_empty;
  logic            deq, req_fire, rsp_drop, rsp_push;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign target_pc  = redirect_pc;
  assign target_mis = |redirect_pc[1:0];
  assign misalign   = misalign_q;

  // Sticky flag: set by a misaligned redirect, cleared by the next aligned one
  always_comb begin
    misalign_d = misalign_q;
    if (redirect_valid) begin
      misalign_d = target_mis;
    end else begin
      misalign_d = misalign_q;
    end
  end

  // Misalign flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`else
  assign target_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  assign target_mis = 1'b0;
  assign misalign   = target_mis;
`endif

  assign fetch_misalign = misalign;

  // Credit counts outstanding requests plus buffered words, net of the word leaving this cycle
  assign deq         = !buf_empty && inst_ready;
  assign credit_used = {1'b0, outst_q} + {1'b0, buf_count} - {{CW{1'b0}}, deq};
  assign imem_req_valid = rst_n && !redirect_valid && !misalign
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && !redirect_valid && (drop_q != '0);
  assign rsp_push = imem_rsp_valid && !redirect_valid && (drop_q == '0)
                    && (outst_q != '0) && (!buf_full || deq);

  assign stale_total = {1'b0, drop_q} + {1'b0, outst_q};

  assign inst_valid = !buf_empty;
  assign inst_pc    = deliver_pc_q;

  // Next-state for PCs and in-flight accounting; redirect outranks everything
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;
    outst_d      = outst_q;
    drop_d       = drop_q;
    if (redirect_valid) begin
      fetch_pc_d   = target_pc;
      deliver_pc_d = target_pc;
      outst_d      = '0;
      if (imem_rsp_valid && (stale_total != '0)) begin
        drop_d = CW'(stale_total - (CW+1)'(1));
      end else begin
        drop_d = CW'(stale_total);
      end
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      else          fetch_pc_d = fetch_pc_q;
      if (deq) deliver_pc_d = deliver_pc_q + PC_STEP;
      else     deliver_pc_d = deliver_pc_q;
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_push);
      if (rsp_drop) drop_d = drop_q - CW'(1);
      else          drop_d = drop_q;
    end
  end

  // PC and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      deliver_pc_q <= RESET_PC;
      outst_q      <= '0;
      drop_q       <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
    end
  end

  inst_buffer #(.DEPTH(DEPTH)) u_inst_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_push),
    .pop_i   (deq),
    .flush_i (redirect_valid),
    .data_i  (imem_rsp_data),
    .head_o  (inst),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model plus a queue-level reference of fetch/delivery.
module tb_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fetch_misalign;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit live; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } item_t;

  mreq_t       memq[$];
  item_t       bufq[$];
  logic [31:0] m_fetch, m_deliver;
  bit          m_mis;
  int          cyc, lat, tests, fails;
  logic        obs_req_valid, obs_inst_valid, obs_mis;
  logic [31:0] obs_req_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (memq[i]) if (memq[i].live) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are checked, then the model advances
  task automatic cycle();
    bit          ev, ereq, deq, acc;
    int          used;
    logic [31:0] tgt;
    mreq_t       r;
    r = '{32'h0, 0, 1'b0};
    imem_rsp_valid = (memq.size() > 0) && (memq[0].due <= cyc);
    imem_rsp_data  = imem_rsp_valid ? memword(memq[0].addr) : 32'hDEAD_BEEF;
    #2;
    ev   = (bufq.size() > 0);
    used = live_cnt() + bufq.size() - ((ev && inst_ready) ? 1 : 0);
    ereq = !redirect_valid && !m_mis && (used < DEPTH);
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ereq});
    chk("req_addr", imem_req_addr, m_fetch);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, ev});
    chk("inst_pc", inst_pc, m_deliver);
    if (ev) chk("inst", inst, bufq[0].data);
    chk("misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
    obs_req_valid  = imem_req_valid;
    obs_req_addr   = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_mis        = fetch_misalign;
    deq = ev && inst_ready;
    acc = imem_req_valid && imem_req_ready;
    if (imem_rsp_valid) r = memq.pop_front();
    if (redirect_valid) begin
      foreach (memq[i]) memq[i].live = 1'b0;
      bufq.delete();
      tgt = redirect_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
      m_mis = (tgt[1:0] != 2'b00);
`else
      tgt[1:0] = 2'b00;
`endif
      m_fetch   = tgt;
      m_deliver = tgt;
    end else begin
      if (deq) begin
        void'(bufq.pop_front());
        m_deliver = m_deliver + 32'd4;
      end
      if (imem_rsp_valid && r.live) bufq.push_back('{r.addr, memword(r.addr)});
      if (acc) begin
        memq.push_back('{imem_req_addr, cyc + lat, 1'b1});
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  task automatic model_reset();
    memq.delete();
    bufq.delete();
    m_fetch   = RESET_PC;
    m_deliver = RESET_PC;
    m_mis     = 1'b0;
  endtask

  initial begin
    int          gap;
    logic [31:0] tpc;
    tests = 0; fails = 0; cyc = 0; lat = 1;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

    // Streaming with single-cycle memory
    rst_n = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    cycle(); chk("t1_addr0", obs_req_addr, 32'h0); chk("t1_iv0", {31'b0, obs_inst_valid}, 32'd0);
    cycle(); chk("t1_addr1", obs_req_addr, 32'h4); chk("t1_iv1", {31'b0, obs_inst_valid}, 32'd0);
    cycle(); chk("t1_addr2", obs_req_addr, 32'h8); chk("t1_iv2", {31'b0, obs_inst_valid}, 32'd1);
    repeat (4) cycle();

    // Decode stall fills the buffer and blocks requests
    inst_ready = 1'b0;
    repeat (10) cycle();
    chk("t2_req_blocked", {31'b0, obs_req_valid}, 32'd0);
    chk("t2_buffered", {31'b0, obs_inst_valid}, 32'd1);
    inst_ready = 1'b1;
    repeat (6) cycle();

    // Slow memory with requests in flight, then redirect
    lat = 3;
    repeat (4) cycle();
    redir(32'h0000_0100);
    repeat (10) cycle();

    // Redirect coinciding with a response and a handshake
    lat = 1;
    repeat (5) cycle();
    redir(32'h0000_0300);
    cycle();
    chk("t4_empty", {31'b0, obs_inst_valid}, 32'd0);
    chk("t4_addr", obs_req_addr, 32'h0000_0300);
    chk("t4_req", {31'b0, obs_req_valid}, 32'd1);
    repeat (3) cycle();

    // Back-to-back redirects: last wins
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400; cycle();
    redirect_pc = 32'h0000_0500; cycle();
    redirect_valid = 1'b0;
    cycle(); chk("b2b_addr", obs_req_addr, 32'h0000_0500);
    repeat (5) cycle();

    // Address wrap
    redir(32'hFFFF_FFF8);
    cycle(); cycle(); cycle();
    chk("wrap_addr", obs_req_addr, 32'h0000_0000);
    repeat (4) cycle();

    // Misaligned redirect target
    redir(32'h0000_0102);
    cycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_flag", {31'b0, obs_mis}, 32'd1);
    chk("mis_noreq", {31'b0, obs_req_valid}, 32'd0);
    repeat (3) cycle();
    redir(32'h0000_0200);
    cycle();
    chk("mis_clear_addr", obs_req_addr, 32'h0000_0200);
    chk("mis_clear_flag", {31'b0, obs_mis}, 32'd0);
`else
    chk("mis_forced_addr", obs_req_addr, 32'h0000_0100);
    chk("mis_tied", {31'b0, obs_mis}, 32'd0);
`endif
    repeat (4) cycle();

    // Reset in mid-operation
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_iv", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_pc", inst_pc, RESET_PC);
    imem_rsp_valid = 1'b0;
    model_reset();
    @(posedge clk);
    cyc++;
    #1 rst_n = 1'b1;
    repeat (4) cycle();

    // Randomized traffic
    gap = 0;
    for (int i = 0; i < 800; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 3);
      gap++;
      if (gap >= 8 && $urandom_range(0, 9) == 0) begin
        gap = 0;
        tpc = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 7) == 0) tpc[1:0] = 2'b10;
        redir(tpc);
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
